// File: rtl/rr_arb_pkg.sv
// Shared types and the wrapping round-robin search used by the weighted arbiter.
package rr_arb_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = 7;

  typedef enum logic {IDLE, GRANT} state_t;

  typedef logic [2*MAX_W-1:0] dvec_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic dvec_t leave_one_hot(input dvec_t v);
    return v & (~v + dvec_t'(1));
  endfunction

  function automatic logic [7:0] pos2bin(input dvec_t oh);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 2*MAX_W; i++)
      if (oh[i]) b = b | 8'(i);
    return b;
  endfunction

  // Request vector is doubled so the window ptr+1..ptr+width is a contiguous
  // mask; the top of the window is ptr itself, so the current owner comes last.
  function automatic pick_t rr_pick(input logic [MAX_W-1:0] req, input int ptr,
                                    input int width);
    dvec_t      dbl;
    dvec_t      mask;
    dvec_t      oh;
    logic [7:0] pos;
    pick_t      r;
    dbl  = '0;
    mask = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < width) begin
        dbl[i]         = req[i];
        dbl[i + width] = req[i];
      end
    for (int j = 0; j < 2*MAX_W; j++)
      mask[j] = (j > ptr) && (j <= ptr + width);
    oh      = leave_one_hot(dbl & mask);
    pos     = pos2bin(oh);
    r.found = |oh;
    r.idx   = (pos >= 8'(width)) ? IDX_W'(pos - 8'(width)) : IDX_W'(pos);
    return r;
  endfunction

endpackage

// File: rtl/rr_credit_cnt.sv
// Per-grant quantum counter: loads on grant, counts beats down, flags last credit.
module rr_credit_cnt #(
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WEIGHT_W-1:0] load_val,
  input  logic                clr,
  input  logic                dec,
  output logic [WEIGHT_W-1:0] credit,
  output logic                exhaust
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      credit <= '0;
    else if (load)
      credit <= (load_val == '0) ? WEIGHT_W'(1) : load_val;
    else if (clr)
      credit <= '0;
    else if (dec)
      credit <= credit - WEIGHT_W'(1);
  end

  assign exhaust = (credit == WEIGHT_W'(1));

endmodule

// File: rtl/round_robin_weighted_arb.sv
// Registered weighted round-robin arbiter with zero-bubble handover between owners.
module round_robin_weighted_arb
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int WIDTH_W  = $clog2(WIDTH),
  parameter int WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          req,
  input  logic [WIDTH*WEIGHT_W-1:0] weight,
  input  logic [WIDTH-1:0]          last,
  input  logic                      ack,
  output logic                      gnt_valid,
  output logic [WIDTH-1:0]          gnt,
  output logic [WIDTH_W-1:0]        gnt_bin,
  output logic [WEIGHT_W-1:0]       credit
);

  state_t               state_q, state_d;
  logic [WIDTH_W-1:0]   ptr_q, ptr_d, ptr_srch;
  logic [WIDTH_W-1:0]   bin_q, bin_d;
  logic [WIDTH-1:0]     gnt_q, gnt_d;
  logic [MAX_W-1:0]     req_ext;
  pick_t                pick;
  logic [WIDTH_W-1:0]   pick_idx;
  logic [WEIGHT_W-1:0]  pick_weight;
  logic                 beat, rel, exhaust;
  logic                 load, clr, dec;
  logic                 unused_pick;

  assign beat = (state_q == GRANT) && ack;
  assign rel  = (state_q == GRANT) &&
                (!req[bin_q] || (beat && (last[bin_q] || exhaust)));

  // On release the search starts just past the departing owner.
  assign ptr_srch = rel ? bin_q : ptr_q;

  always_comb begin
    req_ext               = '0;
    req_ext[WIDTH-1:0]    = req;
    pick                  = rr_pick(req_ext, int'(ptr_srch), WIDTH);
  end

  assign pick_idx    = pick.idx[WIDTH_W-1:0];
  assign pick_weight = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
  assign unused_pick = ^pick.idx;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    gnt_d   = gnt_q;
    load    = 1'b0;
    clr     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d         = GRANT;
          load            = 1'b1;
          bin_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = bin_q;
          if (pick.found) begin
            load            = 1'b1;
            bin_d           = pick_idx;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
          end else begin
            state_d = IDLE;
            clr     = 1'b1;
            bin_d   = '0;
            gnt_d   = '0;
          end
        end else if (beat) begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= WIDTH_W'(WIDTH - 1);
      bin_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bin_q   <= bin_d;
      gnt_q   <= gnt_d;
    end
  end

  rr_credit_cnt #(
    .WEIGHT_W (WEIGHT_W)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (pick_weight),
    .clr      (clr),
    .dec      (dec),
    .credit   (credit),
    .exhaust  (exhaust)
  );

  assign gnt_valid = (state_q == GRANT);
  assign gnt       = gnt_q;
  assign gnt_bin   = bin_q;

endmodule
